// File: rtl/seg_memory_if.sv
// EX/MEM -> MEM/WB bus of the MEM pipeline stage: EX-side inputs and registered WB-side outputs.
interface seg_memory_if #(
  parameter int NB_DATA    = 32,
  parameter int NB_REG     = 5,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 3
);
  logic                              i_enable;
  logic                              i_flush;
  logic [NB_DATA-1:0]                i_ALU_result;
  logic                              i_ALU_zero;
  logic [NB_DATA-1:0]                i_read_data_2;
  logic [NB_REG-1:0]                 i_write_reg;
  logic [NB_CTRL_WB+NB_CTRL_M-1:0]   i_control;
  logic                              o_pc_src;
  logic [NB_DATA-1:0]                o_read_data;
  logic [NB_DATA-1:0]                o_ALU_result;
  logic [NB_REG-1:0]                 o_write_reg;
  logic [NB_CTRL_WB-1:0]             o_control;
  logic                              o_misaligned;

  modport master (
    output i_enable, i_flush, i_ALU_result, i_ALU_zero, i_read_data_2, i_write_reg, i_control,
    input  o_pc_src, o_read_data, o_ALU_result, o_write_reg, o_control, o_misaligned
  );

  modport slave (
    input  i_enable, i_flush, i_ALU_result, i_ALU_zero, i_read_data_2, i_write_reg, i_control,
    output o_pc_src, o_read_data, o_ALU_result, o_write_reg, o_control, o_misaligned
  );
endinterface

// File: rtl/seg_memory.sv
// MIPS MEM stage: data memory (sync write, registered read), branch resolve, MEM/WB latch.
// Optional macro SEG_MEMORY_DEBUG_EN adds an independent registered debug read port.
module seg_memory #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 10,
  parameter int NB_REG     = 5,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  seg_memory_if.slave        bus
`ifdef SEG_MEMORY_DEBUG_EN
  ,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic [NB_DATA-1:0] o_debug_data
`endif
);

  localparam int NB_CTRL    = NB_CTRL_WB + NB_CTRL_M;
  localparam int BIT_BRANCH = 2;
  localparam int BIT_MRD    = 1;
  localparam int BIT_MWR    = 0;
  localparam int MEM_DEPTH  = 2 ** NB_ADDR;

  function automatic logic [NB_ADDR-1:0] word_addr(input logic [NB_DATA-1:0] byte_addr);
    return byte_addr[NB_ADDR+1:2];
  endfunction

  function automatic logic is_misaligned(input logic access, input logic [1:0] low_bits);
    return access && (low_bits != 2'b00);
  endfunction

  logic [NB_DATA-1:0]    mem [MEM_DEPTH];

  logic [NB_CTRL_M-1:0]  ctrl_m_p0;
  logic [NB_CTRL_WB-1:0] ctrl_wb_p0;
  logic                  branch_p0;
  logic                  mem_read_p0;
  logic                  mem_write_p0;
  logic [NB_ADDR-1:0]    addr_p0;
  logic                  misaligned_p0;
  logic                  wr_en_p0;
  logic                  rd_en_p0;

  logic [NB_DATA-1:0]    read_data_p1;
  logic [NB_DATA-1:0]    alu_result_p1;
  logic [NB_REG-1:0]     write_reg_p1;
  logic [NB_CTRL_WB-1:0] ctrl_wb_p1;
  logic                  misaligned_p1;

  // p0: decode of EX/MEM latch contents
  assign ctrl_m_p0     = bus.i_control[NB_CTRL_M-1:0];
  assign ctrl_wb_p0    = bus.i_control[NB_CTRL-1:NB_CTRL_M];
  assign branch_p0     = ctrl_m_p0[BIT_BRANCH];
  assign mem_read_p0   = ctrl_m_p0[BIT_MRD];
  assign mem_write_p0  = ctrl_m_p0[BIT_MWR];
  assign addr_p0       = word_addr(bus.i_ALU_result);
  assign misaligned_p0 = is_misaligned(mem_read_p0 | mem_write_p0, bus.i_ALU_result[1:0]);

  // A store sampled together with reset is dropped; read+write together yields a zero load.
  assign wr_en_p0 = i_rst & bus.i_enable & mem_write_p0 & ~bus.i_flush & ~misaligned_p0;
  assign rd_en_p0 = mem_read_p0 & ~mem_write_p0 & ~misaligned_p0;

  assign bus.o_pc_src = branch_p0 & bus.i_ALU_zero & ~bus.i_flush;

  always_ff @(posedge i_clk) begin
    if (wr_en_p0) begin
      mem[addr_p0] <= bus.i_read_data_2;
    end
  end

  // p1: MEM/WB latch
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      read_data_p1  <= '0;
      alu_result_p1 <= '0;
      write_reg_p1  <= '0;
      ctrl_wb_p1    <= '0;
      misaligned_p1 <= 1'b0;
    end else if (bus.i_enable) begin
      read_data_p1  <= rd_en_p0 ? mem[addr_p0] : '0;
      alu_result_p1 <= bus.i_ALU_result;
      write_reg_p1  <= bus.i_write_reg;
      ctrl_wb_p1    <= bus.i_flush ? '0 : ctrl_wb_p0;
      misaligned_p1 <= bus.i_flush ? 1'b0 : misaligned_p0;
    end
  end

  assign bus.o_read_data  = read_data_p1;
  assign bus.o_ALU_result = alu_result_p1;
  assign bus.o_write_reg  = write_reg_p1;
  assign bus.o_control    = ctrl_wb_p1;
  assign bus.o_misaligned = misaligned_p1;

`ifdef SEG_MEMORY_DEBUG_EN
  logic [NB_DATA-1:0] debug_data_p1;

  // Debug port ignores the stall so a halted pipeline can still be inspected.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      debug_data_p1 <= '0;
    end else begin
      debug_data_p1 <= mem[i_debug_addr];
    end
  end

  assign o_debug_data = debug_data_p1;
`endif

endmodule
